// File: rtl/ifetch_unit_pkg.sv
// Shared CPU definitions: fetch FSM encoding, reset vector and alignment helper.
// Also imported by the PC register and the controller.
package ifetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] CPU_RESET_VECTOR = 32'h0000_3000;
    localparam int          FETCH_CNT_W      = 5;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues one memory read per fetch request and holds the
// returned word in ir until the decoder acknowledges it, with flush and timeout.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = CPU_RESET_VECTOR,
    parameter int          TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_start,
    input  logic        flush,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        ir_ack,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    output logic        busy,
    output logic        fault_misalign,
    output logic        fault_timeout
);

    localparam logic [FETCH_CNT_W-1:0] CNT_LAST = FETCH_CNT_W'(TIMEOUT - 1);

    fetch_state_e           state_q, state_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic [31:0]            ir_q, ir_d;
    logic [31:0]            ir_pc_q, ir_pc_d;
    logic [FETCH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   drop_q, drop_d;
    logic                   misalign_q, misalign_d;
    logic                   timeout_q, timeout_d;

    logic start_ok;
    logic start_bad;

    assign start_ok  = fetch_start &&  is_word_aligned(pc);
    assign start_bad = fetch_start && !is_word_aligned(pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= RESET_VECTOR;
            ir_q       <= '0;
            ir_pc_q    <= RESET_VECTOR;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        misalign_d = 1'b0;
        timeout_d  = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d    = ST_REQ;
                    mem_addr_d = pc;
                    timeout_d  = 1'b0;
                    cnt_d      = '0;
                    drop_d     = 1'b0;
                end else if (start_bad) begin
                    misalign_d = 1'b1;
                end
            end

            ST_REQ: begin
                if (mem_ready) begin
                    // A flush in the same cycle as the data counts as a drop.
                    if (drop_q || flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                        ir_d    = mem_rdata;
                        ir_pc_d = mem_addr_q;
                    end
                    drop_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    drop_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (flush) begin
                        drop_d = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (ir_ack) begin
                    if (start_ok) begin
                        state_d    = ST_REQ;
                        mem_addr_d = pc;
                        timeout_d  = 1'b0;
                        cnt_d      = '0;
                        drop_d     = 1'b0;
                    end else begin
                        state_d    = ST_IDLE;
                        misalign_d = start_bad;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_req        = (state_q == ST_REQ);
    assign ir_valid       = (state_q == ST_HOLD);
    assign busy           = (state_q != ST_IDLE);
    assign mem_addr       = mem_addr_q;
    assign ir             = ir_q;
    assign ir_pc          = ir_pc_q;
    assign fault_misalign = misalign_q;
    assign fault_timeout  = timeout_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: vector table of fetch transactions plus
// hand-written back-to-back, flush, timeout and reset sequences.
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_start;
    logic        flush;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ir_ack;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        busy;
    logic        fault_misalign;
    logic        fault_timeout;

    ifetch_unit #(
        .RESET_VECTOR (32'h0000_3000),
        .TIMEOUT      (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .fetch_start    (fetch_start),
        .flush          (flush),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .ir_ack         (ir_ack),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_valid       (ir_valid),
        .busy           (busy),
        .fault_misalign (fault_misalign),
        .fault_timeout  (fault_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          delay;     // REQ cycles without mem_ready before the data beat
        int          flush_at;  // REQ cycle index carrying flush, 0 = none
        bit          misalign;
        bit          load;
    } vec_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } exp_t;

    exp_t        sbq[$];
    vec_t        vecs[8];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_ir  = 32'h0;
    logic        valid_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rising ir_valid must match the oldest expected load.
    always @(negedge clk) begin
        if (!rst) begin
            if (ir_valid && !valid_prev) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_load", ir, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sb_ir", ir, e.ir);
                    chk("sb_ir_pc", ir_pc, e.pc);
                end
            end
            valid_prev <= ir_valid;
        end else begin
            valid_prev <= 1'b0;
        end
    end

    task automatic run_vec(input vec_t v);
        int nreq;
        pc = v.pc;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        if (v.misalign) begin
            chk("misalign_pulse", fault_misalign, 1);
            chk("misalign_noreq", mem_req, 0);
            chk("misalign_busy", busy, 0);
            tick();
            chk("misalign_once", fault_misalign, 0);
            chk("misalign_idle", {busy, mem_req}, 0);
            return;
        end
        chk("req_addr", mem_addr, v.pc);
        if (v.load) sbq.push_back('{ir: v.rdata, pc: v.pc});
        nreq = 0;
        while (mem_req && nreq < 40) begin
            nreq++;
            if (nreq == v.delay + 1) begin
                mem_ready = 1'b1;
                mem_rdata = v.rdata;
            end
            if (nreq == v.flush_at) flush = 1'b1;
            tick();
            mem_ready = 1'b0;
            flush     = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
        end
        chk("req_cycles", nreq, v.delay + 1);
        if (v.load) begin
            chk("hold_valid", ir_valid, 1);
            pc = v.pc + 32'd4;
            fetch_start = 1'b1;
            tick();
            fetch_start = 1'b0;
            chk("hold_ignore_start", {ir_valid, mem_req}, 2'b10);
            ir_ack = 1'b1;
            tick();
            ir_ack = 1'b0;
            chk("ack_idle", {busy, ir_valid}, 0);
            chk("ack_retain_ir", ir, v.rdata);
            last_ir = v.rdata;
        end else begin
            chk("drop_idle", {busy, ir_valid}, 0);
            chk("drop_ir_kept", ir, last_ir);
        end
    endtask

    initial begin
        int nreq;

        vecs[0] = '{pc: 32'h0000_3000, rdata: 32'h2008_0005, delay: 2, flush_at: 0, misalign: 0, load: 1};
        vecs[1] = '{pc: 32'h0000_3002, rdata: 32'h0,         delay: 0, flush_at: 0, misalign: 1, load: 0};
        vecs[2] = '{pc: 32'h0000_3100, rdata: 32'h1234_5678, delay: 0, flush_at: 0, misalign: 0, load: 1};
        vecs[3] = '{pc: 32'h0000_3004, rdata: 32'hFFFF_FFFF, delay: 2, flush_at: 1, misalign: 0, load: 0};
        vecs[4] = '{pc: 32'h0000_3200, rdata: 32'hCAFE_0001, delay: 1, flush_at: 2, misalign: 0, load: 0};
        vecs[5] = '{pc: 32'h0000_3001, rdata: 32'h0,         delay: 0, flush_at: 0, misalign: 1, load: 0};
        vecs[6] = '{pc: 32'h0000_3003, rdata: 32'h0,         delay: 0, flush_at: 0, misalign: 1, load: 0};
        vecs[7] = '{pc: 32'h0000_3FFC, rdata: 32'hA5A5_5A5A, delay: 5, flush_at: 0, misalign: 0, load: 1};

        rst = 1'b1;
        pc = 32'h0;
        fetch_start = 1'b0;
        flush = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        ir_ack = 1'b0;
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 32'h0000_3000);
        chk("rst_ir", ir, 0);
        chk("rst_ir_pc", ir_pc, 32'h0000_3000);
        chk("rst_flags", {ir_valid, busy, fault_misalign, fault_timeout}, 0);
        tick();
        tick();
        rst = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("idle_flush_noop", busy, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back fetch, then flush while holding.
        pc = 32'h0000_3000;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        sbq.push_back('{ir: 32'h1111_0001, pc: 32'h0000_3000});
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_0001;
        tick();
        mem_ready = 1'b0;
        chk("b2b_hold1", ir_valid, 1);
        ir_ack = 1'b1;
        fetch_start = 1'b1;
        pc = 32'h0000_3004;
        sbq.push_back('{ir: 32'h2222_0002, pc: 32'h0000_3004});
        tick();
        ir_ack = 1'b0;
        fetch_start = 1'b0;
        chk("b2b_req", {mem_req, ir_valid}, 2'b10);
        chk("b2b_addr", mem_addr, 32'h0000_3004);
        mem_ready = 1'b1;
        mem_rdata = 32'h2222_0002;
        tick();
        mem_ready = 1'b0;
        chk("b2b_hold2", ir_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("hold_flush_idle", {busy, ir_valid}, 0);
        chk("hold_flush_ir", ir, 32'h2222_0002);
        last_ir = 32'h2222_0002;

        // Timeout after 16 REQ cycles, cleared by the next aligned fetch.
        pc = 32'h0000_3010;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        nreq = 0;
        while (mem_req && nreq < 40) begin
            nreq++;
            tick();
        end
        chk("timeout_cycles", nreq, 16);
        chk("timeout_flag", fault_timeout, 1);
        chk("timeout_idle", {busy, ir_valid}, 0);
        chk("timeout_ir_kept", ir, last_ir);
        pc = 32'h0000_3014;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("timeout_cleared", {fault_timeout, mem_req}, 2'b01);
        sbq.push_back('{ir: 32'h0BAD_F00D, pc: 32'h0000_3014});
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ready = 1'b0;
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        last_ir = 32'h0BAD_F00D;

        // Reset mid-REQ; a late mem_ready after release must be ignored.
        pc = 32'h0000_3020;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        chk("pre_rst_req", mem_req, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", {mem_req, busy, ir_valid, fault_timeout, fault_misalign}, 0);
        chk("rst_mid_addr", mem_addr, 32'h0000_3000);
        chk("rst_mid_ir", ir, 0);
        chk("rst_mid_ir_pc", ir_pc, 32'h0000_3000);
        tick();
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h7777_7777;
        tick();
        mem_ready = 1'b0;
        chk("post_rst_ready_ignored", {busy, ir_valid}, 0);
        chk("post_rst_ir", ir, 0);

        tick();
        chk("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
